hour_gen: RTL and testbench

Hour counter stage directly downstream of the minute generator: consumes its `min_tic` roll-over strobe and maintains the hour of day (0–23). It also provides a 12/24-hour display value with a PM flag and BCD digits. Set mode is supported with up/down buttons, including hold-to-auto-repeat. `day_tic` is issued for a future day/date stage.

---
 rtl/hour_gen_if.sv | 36 +++
 rtl/hour_gen.sv | 152 +++++++++++++++
 tb/tb_hour_gen.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hour_gen_if.sv
// hour_gen_if: bundles the hour stage's strobes, buttons and display outputs.
//   master : drives min_tic, set_en, btn_up, btn_dn, mode_12; reads the outputs
//   slave  : the hour stage itself (reads the inputs, drives the outputs)
//   min_tic   : one-cycle roll-over strobe from the minute stage
//   set_en    : set mode, buttons step the hour, min_tic ignored
//   btn_up/dn : debounced, synchronised button levels
//   mode_12   : 1 = 12-hour display, 0 = 24-hour display
//   hour      : registered hour of day, 0..23
//   disp_hour : display hour (12/24-hour per mode_12)
//   pm        : hour >= 12
//   hour_bcd  : BCD of disp_hour, tens [7:4], units [3:0]
//   day_tic   : strobe on the 23 -> 0 roll-over, for a day/date stage
interface hour_gen_if #(
    parameter int P_HOUR_BIT = 5
);
    logic                  min_tic;
    logic                  set_en;
    logic                  btn_up;
    logic                  btn_dn;
    logic                  mode_12;
    logic [P_HOUR_BIT-1:0] hour;
    logic [P_HOUR_BIT-1:0] disp_hour;
    logic                  pm;
    logic [7:0]            hour_bcd;
    logic                  day_tic;

    modport master (
        output min_tic, set_en, btn_up, btn_dn, mode_12,
        input  hour, disp_hour, pm, hour_bcd, day_tic
    );

    modport slave (
        input  min_tic, set_en, btn_up, btn_dn, mode_12,
        output hour, disp_hour, pm, hour_bcd, day_tic
    );
endinterface

// File: rtl/hour_gen.sv
// hour_gen: hour-of-day counter fed by the minute stage's roll-over strobe.
// Counts 0..23 on min_tic, or is stepped up/down by buttons in set mode with
// hold-to-auto-repeat. Provides a 12/24-hour display value, PM flag, BCD
// digits and a day_tic strobe for a downstream day/date stage.
// Ports:
//   clk       : single clock, rising edge
//   reset_h   : synchronous active-high reset of this block
//   reset_all : synchronous active-high global reset, same effect
//   bus       : hour_gen_if slave (strobes, buttons, mode in; hour/display out)
module hour_gen #(
    parameter int P_HOUR_BIT  = 5,
    parameter int P_RPT_FIRST = 50_000_000,
    parameter int P_RPT_NEXT  = 10_000_000,
    parameter int P_CNT_BIT   = 26
) (
    input  logic         clk,
    input  logic         reset_h,
    input  logic         reset_all,
    hour_gen_if.slave    bus
);

    localparam logic [P_HOUR_BIT-1:0] HOUR_LAST = P_HOUR_BIT'(23);
    localparam logic [P_HOUR_BIT-1:0] HOUR_NOON = P_HOUR_BIT'(12);
    localparam logic [P_CNT_BIT-1:0]  CNT_FIRST = P_CNT_BIT'(P_RPT_FIRST - 1);
    localparam logic [P_CNT_BIT-1:0]  CNT_NEXT  = P_CNT_BIT'(P_RPT_NEXT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } state_t;

    state_t                state;
    logic [P_CNT_BIT-1:0]  cnt;
    logic [P_HOUR_BIT-1:0] hour;
    logic                  up_d;
    logic                  dn_d;
    logic                  dir_up;

    // One step modulo 24 in either direction.
    function automatic logic [P_HOUR_BIT-1:0] hour_step(
        input logic [P_HOUR_BIT-1:0] h,
        input logic                  up
    );
        if (up)
            return (h == HOUR_LAST) ? '0 : h + 1'b1;
        else
            return (h == '0) ? HOUR_LAST : h - 1'b1;
    endfunction

    function automatic logic [P_HOUR_BIT-1:0] to_disp(
        input logic [P_HOUR_BIT-1:0] h,
        input logic                  m12
    );
        if (!m12)
            return h;
        else if (h == '0)
            return HOUR_NOON;
        else if (h <= HOUR_NOON)
            return h;
        else
            return h - HOUR_NOON;
    endfunction

    // Display values never exceed 23, so a tens digit of 0..2 suffices.
    function automatic logic [7:0] to_bcd(input logic [P_HOUR_BIT-1:0] d);
        if (d >= P_HOUR_BIT'(20))
            return {4'd2, 4'(d - P_HOUR_BIT'(20))};
        else if (d >= P_HOUR_BIT'(10))
            return {4'd1, 4'(d - P_HOUR_BIT'(10))};
        else
            return {4'd0, 4'(d)};
    endfunction

    logic up_rise;
    logic dn_rise;
    logic hold_break;

    assign up_rise = bus.btn_up & ~up_d;
    assign dn_rise = bus.btn_dn & ~dn_d;
    // Leave HOLD/RPT when the latched button is released or the other one joins.
    assign hold_break = dir_up ? (~bus.btn_up | bus.btn_dn)
                               : (~bus.btn_dn | bus.btn_up);

    always_ff @(posedge clk) begin
        if (reset_h | reset_all) begin
            hour  <= '0;
            state <= IDLE;
            cnt   <= '0;
            // History at 1 so a button held through reset does not count as a press.
            up_d  <= 1'b1;
            dn_d  <= 1'b1;
        end else begin
            up_d <= bus.btn_up;
            dn_d <= bus.btn_dn;
            if (!bus.set_en) begin
                state <= IDLE;
                cnt   <= '0;
                if (bus.min_tic)
                    hour <= hour_step(hour, 1'b1);
            end else begin
                case (state)
                    IDLE: begin
                        if (up_rise ^ dn_rise) begin
                            hour   <= hour_step(hour, up_rise);
                            dir_up <= up_rise;
                            cnt    <= '0;
                            state  <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (hold_break) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_FIRST) begin
                            hour  <= hour_step(hour, dir_up);
                            cnt   <= '0;
                            state <= RPT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RPT: begin
                        if (hold_break) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_NEXT) begin
                            hour <= hour_step(hour, dir_up);
                            cnt  <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    logic [P_HOUR_BIT-1:0] disp;

    assign disp          = to_disp(hour, bus.mode_12);
    assign bus.hour      = hour;
    assign bus.disp_hour = disp;
    assign bus.pm        = (hour >= HOUR_NOON);
    assign bus.hour_bcd  = to_bcd(disp);
    assign bus.day_tic   = (hour == HOUR_LAST) & bus.min_tic & ~bus.set_en;

endmodule

// File: tb/tb_hour_gen.sv
// tb_hour_gen: self-checking bench for hour_gen with short repeat timings
// (first repeat after 8 cycles, then every 3).
module tb_hour_gen;

    logic clk;
    logic reset_h;
    logic reset_all;
    int   errors;
    int   checks;
    logic [4:0] exp_q[$];
    logic [4:0] got;

    hour_gen_if #(.P_HOUR_BIT(5)) bus ();

    hour_gen #(
        .P_HOUR_BIT (5),
        .P_RPT_FIRST(8),
        .P_RPT_NEXT (3),
        .P_CNT_BIT  (4)
    ) dut (
        .clk      (clk),
        .reset_h  (reset_h),
        .reset_all(reset_all),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press_up(input int n);
        for (int i = 0; i < n; i++) begin
            bus.btn_up = 1'b1;
            cyc();
            bus.btn_up = 1'b0;
            cyc();
        end
    endtask

    task automatic test_reset();
        reset_h = 1'b1;
        reset_all = 1'b1;
        bus.min_tic = 1'b0;
        bus.set_en = 1'b0;
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        bus.mode_12 = 1'b0;
        cyc();
        cyc();
        reset_h = 1'b0;
        reset_all = 1'b0;
        #1;
        checks++;
        if (bus.hour !== 5'd0) begin
            errors++; $display("FAIL reset_hour: got %0d required 0", bus.hour);
        end
        checks++;
        if (bus.disp_hour !== 5'd0) begin
            errors++; $display("FAIL reset_disp24: got %0d required 0", bus.disp_hour);
        end
        checks++;
        if (bus.pm !== 1'b0) begin
            errors++; $display("FAIL reset_pm: got %0b required 0", bus.pm);
        end
        checks++;
        if (bus.hour_bcd !== 8'h00) begin
            errors++; $display("FAIL reset_bcd24: got %h required 00", bus.hour_bcd);
        end
        checks++;
        if (bus.day_tic !== 1'b0) begin
            errors++; $display("FAIL reset_day_tic: got %0b required 0", bus.day_tic);
        end
        bus.mode_12 = 1'b1;
        #1;
        checks++;
        if (bus.disp_hour !== 5'd12) begin
            errors++; $display("FAIL reset_disp12: got %0d required 12", bus.disp_hour);
        end
        checks++;
        if (bus.hour_bcd !== 8'h12) begin
            errors++; $display("FAIL reset_bcd12: got %h required 12", bus.hour_bcd);
        end
        bus.mode_12 = 1'b0;
        #1;
    endtask

    task automatic test_count_wrap();
        for (int i = 1; i <= 24; i++) begin
            bus.min_tic = 1'b1;
            #1;
            checks++;
            if (bus.day_tic !== (i == 24)) begin
                errors++;
                $display("FAIL wrap_day_tic[%0d]: got %0b required %0b", i, bus.day_tic, (i == 24));
            end
            exp_q.push_back(5'(i % 24));
            cyc();
            bus.min_tic = 1'b0;
            got = exp_q.pop_front();
            checks++;
            if (bus.hour !== got) begin
                errors++; $display("FAIL wrap_hour[%0d]: got %0d required %0d", i, bus.hour, got);
            end
        end
    endtask

    task automatic test_display();
        logic [4:0] tgt  [5] = '{5'd0, 5'd1, 5'd12, 5'd13, 5'd23};
        logic [4:0] d12  [5] = '{5'd12, 5'd1, 5'd12, 5'd1, 5'd11};
        logic       pmx  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] b12  [5] = '{8'h12, 8'h01, 8'h12, 8'h01, 8'h11};
        logic [7:0] b24  [5] = '{8'h00, 8'h01, 8'h12, 8'h13, 8'h23};
        int cur;
        cur = 0;
        for (int k = 0; k < 5; k++) begin
            bus.mode_12 = 1'b1;
            while (cur < int'(tgt[k])) begin
                bus.min_tic = 1'b1;
                cyc();
                cur++;
            end
            bus.min_tic = 1'b0;
            #1;
            checks++;
            if (bus.hour !== tgt[k]) begin
                errors++; $display("FAIL disp_hour_reg[%0d]: got %0d required %0d", k, bus.hour, tgt[k]);
            end
            checks++;
            if (bus.disp_hour !== d12[k]) begin
                errors++; $display("FAIL disp12[%0d]: got %0d required %0d", k, bus.disp_hour, d12[k]);
            end
            checks++;
            if (bus.pm !== pmx[k]) begin
                errors++; $display("FAIL pm[%0d]: got %0b required %0b", k, bus.pm, pmx[k]);
            end
            checks++;
            if (bus.hour_bcd !== b12[k]) begin
                errors++; $display("FAIL bcd12[%0d]: got %h required %h", k, bus.hour_bcd, b12[k]);
            end
            bus.mode_12 = 1'b0;
            #1;
            checks++;
            if (bus.disp_hour !== tgt[k]) begin
                errors++; $display("FAIL disp24[%0d]: got %0d required %0d", k, bus.disp_hour, tgt[k]);
            end
            checks++;
            if (bus.hour_bcd !== b24[k]) begin
                errors++; $display("FAIL bcd24[%0d]: got %h required %h", k, bus.hour_bcd, b24[k]);
            end
        end
    endtask

    task automatic test_set_mode();
        bus.set_en = 1'b1;
        bus.min_tic = 1'b1;
        #1;
        checks++;
        if (bus.day_tic !== 1'b0) begin
            errors++; $display("FAIL set_day_tic_tic: got %0b required 0", bus.day_tic);
        end
        exp_q.push_back(5'd23);
        cyc();
        bus.min_tic = 1'b0;
        got = exp_q.pop_front();
        checks++;
        if (bus.hour !== got) begin
            errors++; $display("FAIL set_ignore_tic: got %0d required %0d", bus.hour, got);
        end
        bus.btn_up = 1'b1;
        bus.min_tic = 1'b1;
        #1;
        checks++;
        if (bus.day_tic !== 1'b0) begin
            errors++; $display("FAIL set_step_day_tic: got %0b required 0", bus.day_tic);
        end
        exp_q.push_back(5'd0);
        cyc();
        bus.btn_up = 1'b0;
        bus.min_tic = 1'b0;
        got = exp_q.pop_front();
        checks++;
        if (bus.hour !== got) begin
            errors++; $display("FAIL set_up_wrap: got %0d required %0d", bus.hour, got);
        end
        cyc();
        bus.btn_dn = 1'b1;
        exp_q.push_back(5'd23);
        cyc();
        bus.btn_dn = 1'b0;
        got = exp_q.pop_front();
        checks++;
        if (bus.hour !== got) begin
            errors++; $display("FAIL set_dn_wrap: got %0d required %0d", bus.hour, got);
        end
        cyc();
    endtask

    task automatic test_auto_repeat();
        int e;
        press_up(6);
        checks++;
        if (bus.hour !== 5'd5) begin
            errors++; $display("FAIL rpt_start: got %0d required 5", bus.hour);
        end
        e = 5;
        bus.btn_up = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 0 || k == 8 || k == 11 || k == 14 || k == 17) e++;
            exp_q.push_back(5'(e));
            cyc();
            got = exp_q.pop_front();
            checks++;
            if (bus.hour !== got) begin
                errors++; $display("FAIL rpt_hold[%0d]: got %0d required %0d", k, bus.hour, got);
            end
        end
        bus.btn_up = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(5'd10);
            cyc();
            got = exp_q.pop_front();
            checks++;
            if (bus.hour !== got) begin
                errors++; $display("FAIL rpt_release[%0d]: got %0d required %0d", k, bus.hour, got);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus.btn_up = 1'b1;
        bus.btn_dn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(5'd10);
            cyc();
            got = exp_q.pop_front();
            checks++;
            if (bus.hour !== got) begin
                errors++; $display("FAIL both_rise[%0d]: got %0d required %0d", k, bus.hour, got);
            end
        end
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        cyc();
        bus.btn_up = 1'b1;
        exp_q.push_back(5'd11);
        cyc();
        got = exp_q.pop_front();
        checks++;
        if (bus.hour !== got) begin
            errors++; $display("FAIL conflict_press: got %0d required %0d", bus.hour, got);
        end
        bus.btn_dn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            exp_q.push_back(5'd11);
            cyc();
            got = exp_q.pop_front();
            checks++;
            if (bus.hour !== got) begin
                errors++; $display("FAIL conflict_hold[%0d]: got %0d required %0d", k, bus.hour, got);
            end
        end
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        cyc();
        bus.btn_up = 1'b1;
        exp_q.push_back(5'd12);
        cyc();
        got = exp_q.pop_front();
        checks++;
        if (bus.hour !== got) begin
            errors++; $display("FAIL setdrop_press: got %0d required %0d", bus.hour, got);
        end
        cyc();
        cyc();
        bus.set_en = 1'b0;
        for (int k = 0; k < 12; k++) begin
            exp_q.push_back(5'd12);
            cyc();
            got = exp_q.pop_front();
            checks++;
            if (bus.hour !== got) begin
                errors++; $display("FAIL setdrop_off[%0d]: got %0d required %0d", k, bus.hour, got);
            end
        end
        bus.set_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(5'd12);
            cyc();
            got = exp_q.pop_front();
            checks++;
            if (bus.hour !== got) begin
                errors++; $display("FAIL setdrop_back[%0d]: got %0d required %0d", k, bus.hour, got);
            end
        end
        bus.btn_up = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid(input bit use_all);
        int h0;
        h0 = int'(bus.hour);
        bus.btn_up = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(5'((h0 + ((k >= 8) ? 2 : 1)) % 24));
            cyc();
            got = exp_q.pop_front();
            checks++;
            if (bus.hour !== got) begin
                errors++; $display("FAIL rstmid_hold[%0d]: got %0d required %0d", k, bus.hour, got);
            end
        end
        if (use_all) reset_all = 1'b1;
        else         reset_h   = 1'b1;
        exp_q.push_back(5'd0);
        cyc();
        reset_all = 1'b0;
        reset_h = 1'b0;
        got = exp_q.pop_front();
        checks++;
        if (bus.hour !== got) begin
            errors++; $display("FAIL rstmid_clear(all=%0b): got %0d required %0d", use_all, bus.hour, got);
        end
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(5'd0);
            cyc();
            got = exp_q.pop_front();
            checks++;
            if (bus.hour !== got) begin
                errors++; $display("FAIL rstmid_held[%0d]: got %0d required %0d", k, bus.hour, got);
            end
        end
        bus.btn_up = 1'b0;
        cyc();
        bus.btn_up = 1'b1;
        exp_q.push_back(5'd1);
        cyc();
        bus.btn_up = 1'b0;
        got = exp_q.pop_front();
        checks++;
        if (bus.hour !== got) begin
            errors++; $display("FAIL rstmid_repress(all=%0b): got %0d required %0d", use_all, bus.hour, got);
        end
        cyc();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_count_wrap();
        test_display();
        test_set_mode();
        test_auto_repeat();
        test_back_to_back();
        test_reset_mid(1'b1);
        test_reset_mid(1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
